// File: rtl/seg_view_controller.sv
// seg_view_controller: timed seven-segment view scheduler.
// Optional macro SEG_HALT_LATCH_EN adds a latched HALT view.
module seg_view_controller #(
  parameter int HOLD_CYCLES = 300_000_000,
  parameter int CNT_W       = 29
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_btn_result,
  input  logic        i_btn_instr,
  input  logic        i_btn_flags,
  input  logic        i_cpu_started,
  input  logic        i_halt,
  input  logic [7:0]  i_max_addr,
  input  logic [7:0]  i_pc,
  input  logic [7:0]  i_opcode,
  input  logic [15:0] i_result_high,
  input  logic [15:0] i_result_low,
  input  logic [4:0]  i_flags,
  output logic [31:0] o_seg_data,
  output logic [2:0]  o_view,
  output logic        o_user_sample
);

  typedef enum logic [2:0] {
    ADDR  = 3'd0,
    LIVE  = 3'd1,
    H_RES = 3'd2,
    H_INS = 3'd3,
    H_FLG = 3'd4,
    HALT  = 3'd5
  } view_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(HOLD_CYCLES - 1);

  view_t            state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      res_word;
  logic [31:0]      ins_word;
  logic [31:0]      flg_word;
  logic [31:0]      adr_word;
  logic             halt_edge;

  assign res_word = {i_result_high, i_result_low};
  assign ins_word = {16'b0, i_pc, i_opcode};
  assign flg_word = {27'b0, i_flags};
  assign adr_word = {24'b0, i_max_addr};
  assign o_view   = state;

`ifdef SEG_HALT_LATCH_EN
  logic halt_prev;

  // Previous halt level for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) halt_prev <= 1'b0;
    else          halt_prev <= i_halt;
  end

  assign halt_edge = i_halt & ~halt_prev;
`else
  logic unused_halt;
  assign unused_halt = i_halt;
  assign halt_edge   = 1'b0;
`endif

  // View FSM: requests first, then halt edge, then hold/default.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= ADDR;
      cnt           <= '0;
      o_seg_data    <= '0;
      o_user_sample <= 1'b0;
    end else begin
      o_user_sample <= 1'b0;
      if (i_btn_instr) begin
        state         <= H_INS;
        o_seg_data    <= ins_word;
        cnt           <= '0;
        o_user_sample <= 1'b1;
      end else if (i_btn_flags) begin
        state         <= H_FLG;
        o_seg_data    <= flg_word;
        cnt           <= '0;
        o_user_sample <= 1'b1;
      end else if (i_btn_result) begin
        state         <= H_RES;
        o_seg_data    <= res_word;
        cnt           <= '0;
        o_user_sample <= 1'b1;
      end else if (halt_edge) begin
        state      <= HALT;
        o_seg_data <= res_word;
        cnt        <= '0;
      end else begin
        case (state)
          H_RES, H_INS, H_FLG: begin
            if (cnt == LAST) begin
              cnt        <= '0;
              state      <= i_cpu_started ? LIVE : ADDR;
              o_seg_data <= i_cpu_started ? res_word
                                          : adr_word;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HALT: begin
            state <= HALT;
          end
          default: begin
            cnt        <= '0;
            state      <= i_cpu_started ? LIVE : ADDR;
            o_seg_data <= i_cpu_started ? res_word
                                        : adr_word;
          end
        endcase
      end
    end
  end

endmodule
